// File: rtl/ser_add_pkg.sv
// Shared constants for the bit-serial adder host: FSM encodings, default
// geometry and the cycle-counter width helper.
package ser_add_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_PIPE_LAT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Bits needed to hold values 0..span-1 (ceil(log2(span)), minimum 1).
  function automatic int cnt_width(input int span);
    int w;
    for (w = 1; (1 << w) < span; w++) begin
    end
    return w;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// WIDTH-bit shift register: parallel load, right shift with serial input at
// the MSB. Used both to serialise operands (q[0] is the serial bit) and to
// deserialise the LSB-first sum stream.
module ser_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pdata,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // NOTE: the storage is reset with everything else, so an aborted word never
  // leaves stale bits on the serial lines or in the capture staging.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignment; every flop samples the pre-edge value.
      q <= pdata;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ser_add_host.sv
// Host side of the bit-serial adder: parallel operands in, LSB-first serial
// A/B out, serial sum (plus final carry) captured back into a parallel word.
// Define SER_ADD_HOST_OVF_EN to add the signed-overflow output out_ovf.
module ser_add_host
  import ser_add_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_en,
  input  logic             ser_sum,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
`ifdef SER_ADD_HOST_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH + PIPE_LAT + 2);

  // cnt holds j-1 while edge e(j) is pending, so each event compares against j-1.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CAP_LO   = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] CAP_HI   = CNT_W'(PIPE_LAT + WIDTH - 1);
  localparam logic [CNT_W-1:0] DONE     = CNT_W'(PIPE_LAT + WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             op_shift;
  logic             cap_shift;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             unused_op_bits;

  assign busy     = (state != ST_IDLE);
  assign in_ready = rst & (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign op_shift = (state == ST_SHIFT);

  // Capture follows the counter alone so it may overlap SHIFT/FLUSH.
  assign cap_shift = (cnt >= CAP_LO) && (cnt <= CAP_HI);

  // q[0] of each operand register is the registered serial line; shifting in
  // zeros leaves it at 0 once all WIDTH bits have gone out.
  assign ser_a = a_q[0];
  assign ser_b = b_q[0];
  assign unused_op_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

  ser_shift_reg #(.WIDTH(WIDTH)) u_op_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (op_shift),
    .pdata (in_a),
    .sin   (1'b0),
    .q     (a_q)
  );

  ser_shift_reg #(.WIDTH(WIDTH)) u_op_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (op_shift),
    .pdata (in_b),
    .sin   (1'b0),
    .q     (b_q)
  );

  ser_shift_reg #(.WIDTH(WIDTH)) u_sum (
    .clk   (clk),
    .rst   (rst),
    .load  (1'b0),
    .shift (cap_shift),
    .pdata ({WIDTH{1'b0}}),
    .sin   (ser_sum),
    .q     (sum_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ser_en    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            ser_en <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_BIT) begin
            ser_en <= 1'b0;
            state  <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Zeros go in this cycle: the sum bit is the pending carry and the
          // adder's carry register clears for the next word.
          cnt   <= cnt + CNT_ONE;
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cnt == DONE) begin
            cnt       <= '0;
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            out_sum   <= sum_q;
            out_carry <= ser_sum;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SER_ADD_HOST_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= in_a[WIDTH-1];
        b_msb <= in_b[WIDTH-1];
      end
      // Carry into the MSB differs from carry out of it on signed overflow.
      if ((state == ST_DRAIN) && (cnt == DONE)) begin
        out_ovf <= a_msb ^ b_msb ^ sum_q[WIDTH-1] ^ ser_sum;
      end
    end
  end
`endif

endmodule
